// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_stage                                                         |
// | Pipeline MEM stage: data-memory req/ack access, upstream stall, MEM/WB   |
// | register, sticky error on misaligned or timed-out accesses.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_access_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_EM,
  input  logic        MemtoReg_EM,
  input  logic        MemRead_EM,
  input  logic        MemWrite_EM,
  input  logic [4:0]  Addr_EM,
  input  logic [31:0] Rt_data_EM,
  input  logic [31:0] ALUResult_EM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_MEM,
  output logic        write_MW,
  output logic        MemtoReg_MW,
  output logic [4:0]  Addr_MW,
  output logic [31:0] ReadData_MW,
  output logic [31:0] ALUResult_MW,
  output logic        mem_err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_WAIT   = 1'b1;
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  logic [0:0] state;
  logic [0:0] next_state;
  logic [7:0] wait_cnt;

  logic memop;
  logic aligned;
  logic misaligned;
  logic timeout;
  logic complete;

  assign memop      = MemRead_EM | MemWrite_EM;
  assign aligned    = (ALUResult_EM[1:0] == 2'b00);
  assign misaligned = memop & ~aligned;

  assign dmem_we    = MemWrite_EM;
  assign dmem_addr  = ALUResult_EM;
  assign dmem_wdata = Rt_data_EM;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (memop && aligned && !dmem_ack) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_ack || timeout) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic; request and stall are masked while reset is held
  always_comb begin
    dmem_req  = 1'b0;
    stall_MEM = 1'b0;
    timeout   = 1'b0;
    complete  = 1'b0;
    case (state)
      S_IDLE: begin
        if (memop && aligned) begin
          dmem_req  = 1'b1;
          stall_MEM = ~dmem_ack;
          complete  = dmem_ack;
        end
      end
      S_WAIT: begin
        dmem_req  = 1'b1;
        timeout   = ~dmem_ack & (wait_cnt == LAST_CNT);
        complete  = dmem_ack;
        stall_MEM = ~dmem_ack & ~timeout;
      end
      default: begin
        dmem_req = 1'b0;
      end
    endcase
    if (reset) begin
      dmem_req  = 1'b0;
      stall_MEM = 1'b0;
    end
  end

  // Wait counter sits at zero in IDLE, so the first WAIT cycle sees 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (state == S_IDLE) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_err <= 1'b0;
    end else if (misaligned || timeout) begin
      mem_err <= 1'b1;
    end
  end

  // MEM/WB boundary register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_MW     <= 1'b0;
      MemtoReg_MW  <= 1'b0;
      Addr_MW      <= 5'd0;
      ALUResult_MW <= 32'd0;
      ReadData_MW  <= 32'd0;
    end else begin
      if (stall_MEM) begin
        write_MW    <= 1'b0;
        MemtoReg_MW <= 1'b0;
      end else begin
        write_MW     <= write_EM & ~misaligned & ~timeout;
        MemtoReg_MW  <= MemtoReg_EM;
        Addr_MW      <= Addr_EM;
        ALUResult_MW <= ALUResult_EM;
      end
      if (complete && !MemWrite_EM) begin
        ReadData_MW <= dmem_rdata;
      end
    end
  end

endmodule
`default_nettype wire
